// File: rtl/instruction_fetch_unit.sv
// Fetch requester: PC/read strobe toward InstructionMemory, 2-entry skid FIFO toward the decoder.
// Latency rd_en -> dec_valid is 2 cycles; dec_ready low with a full FIFO stalls issue, nothing is lost.
module instruction_fetch_unit #(
    parameter int  INST_WIDTH = 32,
    parameter int  INST_DEPTH = 16,
    parameter int  RESET_PC   = 0,
    parameter int  WRAP       = 1,
    localparam int AW         = $clog2(INST_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_en,
    output logic                  rd_en,
    output logic [AW-1:0]         rd_addr,
    input  logic [INST_WIDTH-1:0] instruction,
    output logic                  dec_valid,
    input  logic                  dec_ready,
    output logic [INST_WIDTH-1:0] dec_instr,
    output logic [AW-1:0]         dec_pc,
    input  logic                  redirect_valid,
    input  logic [AW-1:0]         redirect_addr,
    output logic                  halted
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [AW-1:0]         pc_q, pc_d;
    logic                  inflight_q, inflight_d;
    logic [AW-1:0]         inflight_pc_q, inflight_pc_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [INST_WIDTH-1:0] head_instr_q, head_instr_d;
    logic [AW-1:0]         head_pc_q, head_pc_d;
    logic [INST_WIDTH-1:0] tail_instr_q, tail_instr_d;
    logic [AW-1:0]         tail_pc_q, tail_pc_d;

    logic [2:0] occ;
    logic       pop_req;
    logic       pop;
    logic       push;
    logic       last_addr;

    assign rd_addr   = pc_q;
    assign dec_valid = (cnt_q != 2'd0);
    assign dec_instr = head_instr_q;
    assign dec_pc    = head_pc_q;
    assign halted    = (state_q == HALT);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_pc_d = pc_q;
        cnt_d         = cnt_q;
        head_instr_d  = head_instr_q;
        head_pc_d     = head_pc_q;
        tail_instr_d  = tail_instr_q;
        tail_pc_d     = tail_pc_q;

        occ       = 3'(cnt_q) + 3'(inflight_q);
        pop_req   = dec_valid && dec_ready;
        pop       = pop_req && !redirect_valid;
        push      = inflight_q && !redirect_valid;
        last_addr = (pc_q == AW'(INST_DEPTH - 1));
        rd_en     = (state_q == RUN) && !redirect_valid && ((occ < 3'd2) || pop_req);
        // A redirect forces rd_en low, so this also squashes any in-flight response.
        inflight_d = rd_en;

        if (redirect_valid) begin
            pc_d = redirect_addr;
        end else if (rd_en) begin
            pc_d = pc_q + 1'b1;
        end

        if (redirect_valid) begin
            state_d = fetch_en ? RUN : IDLE;
        end else begin
            unique case (state_q)
                IDLE: if (fetch_en) state_d = RUN;
                RUN: begin
                    if (rd_en && last_addr && (WRAP == 0)) state_d = HALT;
                    else if (!fetch_en)                    state_d = IDLE;
                end
                HALT: state_d = HALT;
                default: state_d = IDLE;
            endcase
        end

        // Head slot is the decoder-facing register; it keeps its value when the FIFO drains.
        if (redirect_valid) begin
            cnt_d = 2'd0;
        end else begin
            unique case (cnt_q)
                2'd0: begin
                    if (push) begin
                        head_instr_d = instruction;
                        head_pc_d    = inflight_pc_q;
                        cnt_d        = 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head_instr_d = instruction;
                        head_pc_d    = inflight_pc_q;
                    end else if (push) begin
                        tail_instr_d = instruction;
                        tail_pc_d    = inflight_pc_q;
                        cnt_d        = 2'd2;
                    end else if (pop) begin
                        cnt_d = 2'd0;
                    end
                end
                2'd2: begin
                    if (pop) begin
                        head_instr_d = tail_instr_q;
                        head_pc_d    = tail_pc_q;
                        if (push) begin
                            tail_instr_d = instruction;
                            tail_pc_d    = inflight_pc_q;
                        end else begin
                            cnt_d = 2'd1;
                        end
                    end
                end
                default: cnt_d = 2'd0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            pc_q          <= AW'(RESET_PC);
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            cnt_q         <= 2'd0;
            head_instr_q  <= '0;
            head_pc_q     <= '0;
            tail_instr_q  <= '0;
            tail_pc_q     <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            cnt_q         <= cnt_d;
            head_instr_q  <= head_instr_d;
            head_pc_q     <= head_pc_d;
            tail_instr_q  <= tail_instr_d;
            tail_pc_q     <= tail_pc_d;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Two fetch units (WRAP=1 and WRAP=0) share stimulus; each is compared every cycle
// against a behavioural model, plus directed literal expectations per scenario.
module tb_instruction_fetch_unit;

    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_HALT = 2;
    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en, dec_ready, redirect_valid;
    logic [3:0]  redirect_addr;

    logic        rd_en0, rd_en1, dec_valid0, dec_valid1, halted0, halted1;
    logic [3:0]  rd_addr0, rd_addr1, dec_pc0, dec_pc1;
    logic [31:0] instr0, instr1, dec_instr0, dec_instr1;

    logic        a_rd_en [2];
    logic        a_dec_valid [2];
    logic        a_halted [2];
    logic [3:0]  a_rd_addr [2];
    logic [3:0]  a_dec_pc [2];
    logic [31:0] a_dec_instr [2];

    assign a_rd_en[0] = rd_en0;         assign a_rd_en[1] = rd_en1;
    assign a_dec_valid[0] = dec_valid0; assign a_dec_valid[1] = dec_valid1;
    assign a_halted[0] = halted0;       assign a_halted[1] = halted1;
    assign a_rd_addr[0] = rd_addr0;     assign a_rd_addr[1] = rd_addr1;
    assign a_dec_pc[0] = dec_pc0;       assign a_dec_pc[1] = dec_pc1;
    assign a_dec_instr[0] = dec_instr0; assign a_dec_instr[1] = dec_instr1;

    always #5 clk = ~clk;

    logic [31:0] mem [16];
    initial for (int k = 0; k < 16; k++) mem[k] = BASE + 32'(k);

    always @(posedge clk) begin
        if (rd_en0) instr0 <= mem[rd_addr0];
        if (rd_en1) instr1 <= mem[rd_addr1];
    end

    instruction_fetch_unit #(.INST_WIDTH(32), .INST_DEPTH(16), .RESET_PC(0), .WRAP(1)) u_wrap (
        .clk(clk), .rst(rst), .fetch_en(fetch_en), .rd_en(rd_en0), .rd_addr(rd_addr0),
        .instruction(instr0), .dec_valid(dec_valid0), .dec_ready(dec_ready),
        .dec_instr(dec_instr0), .dec_pc(dec_pc0), .redirect_valid(redirect_valid),
        .redirect_addr(redirect_addr), .halted(halted0)
    );

    instruction_fetch_unit #(.INST_WIDTH(32), .INST_DEPTH(16), .RESET_PC(0), .WRAP(0)) u_halt (
        .clk(clk), .rst(rst), .fetch_en(fetch_en), .rd_en(rd_en1), .rd_addr(rd_addr1),
        .instruction(instr1), .dec_valid(dec_valid1), .dec_ready(dec_ready),
        .dec_instr(dec_instr1), .dec_pc(dec_pc1), .redirect_valid(redirect_valid),
        .redirect_addr(redirect_addr), .halted(halted1)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Words actually accepted by the decoder, per instance.
    logic [31:0] dlv0 [$];
    logic [31:0] dlv1 [$];
    logic [3:0]  dpc0 [$];
    logic [3:0]  dpc1 [$];

    task automatic chk_word(input string name, input int which, input int idx, input int addr);
        logic [31:0] w;
        logic [3:0]  p;
        int          sz;
        sz = (which == 0) ? dlv0.size() : dlv1.size();
        if (idx >= sz) begin
            n_chk++;
            $display("FAIL %s: word #%0d never delivered, expected 0x%0h", name, idx, BASE + 32'(addr));
        end else begin
            if (which == 0) begin w = dlv0[idx]; p = dpc0[idx]; end
            else            begin w = dlv1[idx]; p = dpc1[idx]; end
            chk(name, w, BASE + 32'(addr));
            chk({name, "_pc"}, 32'(p), 32'(addr));
        end
    endtask

    task automatic chk_seq(input string name, input int from, input int first, input int n);
        for (int k = 0; k < n; k++) chk_word(name, 0, from + k, (first + k) % 16);
    endtask

    // Model state: queue of pending word addresses plus one in-flight read.
    int          m_st [2];
    int          m_pc [2];
    int          m_infl [2];
    int          m_ipc [2];
    int          m_q [2][$];
    logic [31:0] m_li [2];
    int          m_lp [2];

    always begin
        @(negedge clk);
        #2;
        for (int i = 0; i < 2; i++) begin
            int          occ;
            bit          exp_v, exp_rd, popped, halt_now;
            logic [31:0] exp_i;
            int          exp_p;
            if (rst) begin
                m_st[i] = S_IDLE; m_pc[i] = 0; m_infl[i] = 0; m_ipc[i] = 0;
                m_q[i].delete(); m_li[i] = 32'h0; m_lp[i] = 0;
            end else begin
                occ    = m_q[i].size() + m_infl[i];
                exp_v  = m_q[i].size() > 0;
                exp_rd = (m_st[i] == S_RUN) && !redirect_valid && (occ < 2 || (exp_v && dec_ready));
                exp_i  = exp_v ? BASE + 32'(m_q[i][0]) : m_li[i];
                exp_p  = exp_v ? m_q[i][0] : m_lp[i];
                chk($sformatf("u%0d_rd_en", i),     32'(a_rd_en[i]),     32'(exp_rd));
                chk($sformatf("u%0d_rd_addr", i),   32'(a_rd_addr[i]),   32'(m_pc[i]));
                chk($sformatf("u%0d_dec_valid", i), 32'(a_dec_valid[i]), 32'(exp_v));
                chk($sformatf("u%0d_dec_instr", i), a_dec_instr[i],      exp_i);
                chk($sformatf("u%0d_dec_pc", i),    32'(a_dec_pc[i]),    32'(exp_p));
                chk($sformatf("u%0d_halted", i),    32'(a_halted[i]),    32'(m_st[i] == S_HALT));

                if (a_dec_valid[i] && dec_ready && !redirect_valid) begin
                    if (i == 0) begin dlv0.push_back(a_dec_instr[i]); dpc0.push_back(a_dec_pc[i]); end
                    else        begin dlv1.push_back(a_dec_instr[i]); dpc1.push_back(a_dec_pc[i]); end
                end

                if (redirect_valid) begin
                    m_q[i].delete();
                    m_infl[i] = 0;
                    m_pc[i]   = int'(redirect_addr);
                    m_st[i]   = fetch_en ? S_RUN : S_IDLE;
                end else begin
                    popped = exp_v && dec_ready;
                    if (popped) void'(m_q[i].pop_front());
                    if (m_infl[i] != 0) begin
                        if (m_q[i].size() >= 2) chk($sformatf("u%0d_no_overflow", i), 32'd1, 32'd0);
                        else m_q[i].push_back(m_ipc[i]);
                    end
                    m_infl[i] = exp_rd ? 1 : 0;
                    m_ipc[i]  = m_pc[i];
                    halt_now  = exp_rd && (m_pc[i] == 15) && (i == 1);
                    if (exp_rd) m_pc[i] = (m_pc[i] + 1) % 16;
                    if (halt_now)                            m_st[i] = S_HALT;
                    else if (m_st[i] == S_IDLE && fetch_en)  m_st[i] = S_RUN;
                    else if (m_st[i] == S_RUN && !fetch_en)  m_st[i] = S_IDLE;
                end
                if (m_q[i].size() > 0) begin
                    m_li[i] = BASE + 32'(m_q[i][0]);
                    m_lp[i] = m_q[i][0];
                end
            end
        end
    end

    int   mark0, mark1, mr0, mr1;
    logic [3:0] frozen;

    initial begin
        rst = 1'b1; fetch_en = 1'b0; dec_ready = 1'b0;
        redirect_valid = 1'b0; redirect_addr = 4'd0;

        // Reset and streaming start-up
        repeat (2) @(negedge clk);
        #4;
        chk("rst_rd_en", 32'(rd_en0 | rd_en1), 32'd0);
        chk("rst_dec_valid", 32'(dec_valid0 | dec_valid1), 32'd0);
        @(negedge clk); rst = 1'b0;
        #4;
        chk("rst_halted", 32'(halted0 | halted1), 32'd0);
        chk("rst_dec_instr", dec_instr0, 32'h0);
        chk("rst_dec_pc", 32'(dec_pc0), 32'd0);
        chk("rst_rd_addr", 32'(rd_addr0), 32'd0);
        @(negedge clk); fetch_en = 1'b1; dec_ready = 1'b1;
        #4; chk("start_no_rd", 32'(rd_en0), 32'd0);
        @(negedge clk); #4;
        chk("first_rd_en", 32'(rd_en0), 32'd1);
        @(negedge clk); #4;
        chk("lat_not_yet", 32'(dec_valid0), 32'd0);
        @(negedge clk); #4;
        chk("lat_valid", 32'(dec_valid0), 32'd1);
        chk("lat_instr", dec_instr0, 32'h1000_0000);
        repeat (16) @(negedge clk);
        #4;
        for (int k = 0; k < 17; k++) chk_word("stream", 0, k, k % 16);
        chk("halt_count", 32'(dlv1.size()), 32'd16);
        chk_word("halt_last_word", 1, 15, 15);
        chk("halt_flag", 32'(halted1), 32'd1);
        chk("halt_no_rd", 32'(rd_en1), 32'd0);

        // Redirect to 2 leaves HALT and resumes
        @(negedge clk); redirect_valid = 1'b1; redirect_addr = 4'd2;
        mark0 = dlv0.size(); mark1 = dlv1.size();
        @(negedge clk); redirect_valid = 1'b0;
        repeat (3) @(negedge clk);
        #4;
        chk_word("resume2", 1, mark1, 2);
        chk("resume_halted", 32'(halted1), 32'd0);

        // Backpressure: 5 stalled cycles
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); dec_ready = 1'b0;
            #4;
            if (k == 1) frozen = rd_addr0;
            if (k == 4) begin
                chk("bp_full_valid", 32'(dec_valid0), 32'd1);
                chk("bp_no_rd", 32'(rd_en0), 32'd0);
                chk("bp_pc_frozen", 32'(rd_addr0), 32'(frozen));
            end
        end
        @(negedge clk); dec_ready = 1'b1;
        repeat (5) @(negedge clk);
        #4;
        chk_seq("bp_seq", mark0, 2, 8);

        // Redirect to 9 with words 3 (queued) and 4 (in flight) pending
        @(negedge clk); redirect_valid = 1'b1; redirect_addr = 4'd3; dec_ready = 1'b0;
        @(negedge clk); redirect_valid = 1'b0;
        mark0 = dlv0.size();
        @(negedge clk);
        @(negedge clk); redirect_valid = 1'b1; redirect_addr = 4'd9;
        #4;
        chk("pend_valid", 32'(dec_valid0), 32'd1);
        chk("pend_pc", 32'(dec_pc0), 32'd3);
        @(negedge clk); redirect_valid = 1'b0; dec_ready = 1'b1;
        #4;
        chk("redir_flushed", 32'(dec_valid0), 32'd0);
        chk("redir_addr", 32'(rd_addr0), 32'd9);
        repeat (4) @(negedge clk);
        #4;
        chk_word("redir9", 0, mark0, 9);

        // fetch_en dropped for one cycle
        @(negedge clk); fetch_en = 1'b0;
        @(negedge clk); fetch_en = 1'b1;
        #4; chk("fe_gap_no_rd", 32'(rd_en0), 32'd0);
        repeat (10) @(negedge clk);
        #4;
        chk_seq("fe_seq", mark0, 9, 10);

        // Asynchronous reset between edges
        @(negedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_rd_en", 32'(rd_en0 | rd_en1), 32'd0);
        chk("arst_dec_valid", 32'(dec_valid0 | dec_valid1), 32'd0);
        chk("arst_halted", 32'(halted0 | halted1), 32'd0);
        @(negedge clk);
        @(negedge clk); rst = 1'b0;
        mr0 = dlv0.size(); mr1 = dlv1.size();
        repeat (5) @(negedge clk);
        #4;
        chk_word("arst_restart", 0, mr0, 0);
        chk_word("arst_restart_h", 1, mr1, 0);

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            dec_ready      = ($urandom_range(0, 3) != 0);
            fetch_en       = ($urandom_range(0, 15) != 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_addr  = 4'($urandom_range(0, 15));
        end
        @(negedge clk);
        redirect_valid = 1'b0;
        repeat (3) @(negedge clk);
        #4;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
